// File: rtl/neuron_feeder.sv
// Weight/input RAM server for one MLP neuron evaluation: host-loaded RAMs and bias,
// 1-cycle read beats, and clear/done framing around a W_NUM-request stream.
module neuron_feeder #(
  parameter int W_NUM  = 784,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              pi_clk,
  input  logic              pi_rst,
  input  logic              pi_start,
  output logic              po_busy,
  output logic              po_done,
  input  logic              pi_wr_en,
  input  logic [1:0]        pi_wr_sel,
  input  logic [ADDR_W-1:0] pi_wr_add,
  input  logic [DATA_W-1:0] pi_wr_data,
  output logic              po_wr_err,
  input  logic              pi_bram_en,
  input  logic [ADDR_W-1:0] pi_bram_add,
  output logic              po_valid,
  output logic [DATA_W-1:0] po_weight,
  output logic [DATA_W-1:0] po_input,
  output logic [DATA_W-1:0] po_bias,
  output logic              po_clc_accumulator,
  output logic              po_accumulation_done,
  output logic              po_addr_err
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W:0] W_LIM = (ADDR_W+1)'(W_NUM);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d, cnt_inc;
  logic              valid_q, valid_d;
  logic              oob_q, oob_d;
  logic              addr_err_q, addr_err_d;
  logic              wr_err_q, wr_err_d;
  logic [DATA_W-1:0] bias_q, bias_d;
  logic [DATA_W-1:0] weight_q, weight_d;
  logic [DATA_W-1:0] input_q, input_d;

  logic [DATA_W-1:0] weight_ram [W_NUM];
  logic [DATA_W-1:0] input_ram  [W_NUM];

  logic              rd_acc, rd_in_range, wr_acc, wr_in_range, start_acc;
  logic [ADDR_W-1:0] rd_idx;

  always_comb begin
    rd_in_range = {1'b0, pi_bram_add} < W_LIM;
    wr_in_range = {1'b0, pi_wr_add} < W_LIM;
    rd_acc      = (state_q == S_STREAM) && pi_bram_en;
    start_acc   = (state_q == S_IDLE) && pi_start;
    wr_acc      = pi_wr_en && (state_q == S_IDLE) && (pi_wr_sel != 2'b11) &&
                  ((pi_wr_sel == 2'b10) || wr_in_range);
    rd_idx      = rd_in_range ? pi_bram_add : '0;
    cnt_inc     = cnt_q + 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_err_d = addr_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          state_d    = S_CLEAR;
          addr_err_d = 1'b0;
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (rd_acc) begin
          cnt_d = cnt_inc;
          if (!rd_in_range) addr_err_d = 1'b1;
          if (cnt_inc == W_LIM) state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    valid_d  = rd_acc;
    oob_d    = rd_acc && !rd_in_range;
    weight_d = weight_ram[rd_idx];
    input_d  = input_ram[rd_idx];
    wr_err_d = pi_wr_en && !wr_acc;
    bias_d   = (wr_acc && pi_wr_sel == 2'b10) ? pi_wr_data : bias_q;
  end

  always_ff @(posedge pi_clk or negedge pi_rst) begin
    if (!pi_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      oob_q      <= 1'b0;
      addr_err_q <= 1'b0;
      wr_err_q   <= 1'b0;
      bias_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      oob_q      <= oob_d;
      addr_err_q <= addr_err_d;
      wr_err_q   <= wr_err_d;
      bias_q     <= bias_d;
    end
  end

  // RAM arrays and read registers carry no reset so they map onto block RAM.
  always_ff @(posedge pi_clk) begin
    if (wr_acc && pi_wr_sel == 2'b00) weight_ram[pi_wr_add] <= pi_wr_data;
    if (wr_acc && pi_wr_sel == 2'b01) input_ram[pi_wr_add]  <= pi_wr_data;
    weight_q <= weight_d;
    input_q  <= input_d;
  end

  // Beat data is gated by the reset flops, so it reads 0 without a beat or out of range.
  always_comb begin
    po_valid             = valid_q;
    po_weight            = (valid_q && !oob_q) ? weight_q : '0;
    po_input             = (valid_q && !oob_q) ? input_q  : '0;
    po_bias              = bias_q;
    po_busy              = (state_q != S_IDLE);
    po_clc_accumulator   = (state_q == S_CLEAR);
    po_done              = (state_q == S_DONE);
    po_accumulation_done = (state_q == S_DONE);
    po_addr_err          = addr_err_q;
    po_wr_err            = wr_err_q;
  end

endmodule

// File: doc/neuron_feeder.md
# neuron_feeder

- Serves the data and control side of one MLP neuron's memory interface for a single neuron evaluation.
- Holds W_NUM weights and W_NUM inputs in local RAM, plus a bias register, all loaded by a host write port.
- Answers the neuron's BRAM read requests (en, address) with weight/input pairs one cycle later, and frames the evaluation with an accumulator-clear pulse and an accumulation-done pulse.
- Sits between the layer loader and the neuron datapath.

## Interface
- W_NUM, 784, number of weight/input pairs per neuron evaluation
- DATA_W, 16, width of weight, input and bias words (two's complement fixed point, passed through unmodified)
- ADDR_W, 10, address width, must satisfy 2**ADDR_W >= W_NUM

Ports:
- pi_clk  in  1  clock, all logic on rising edge
- pi_rst  in  1  asynchronous, active-low reset
- pi_start  in  1  start one evaluation (sampled only in IDLE)
- po_busy  out  1  high from the cycle after start is accepted until IDLE is re-entered
- po_done  out  1  one-cycle pulse at end of evaluation
- pi_wr_en  in  1  host write strobe
- pi_wr_sel  in  2  00 weight RAM, 01 input RAM, 10 bias register, 11 reserved (ignored)
- pi_wr_add  in  ADDR_W  host write address (ignored for bias)
- pi_wr_data  in  DATA_W  host write data
- po_wr_err  out  1  one-cycle pulse when a write is rejected
- pi_bram_en  in  1  read request from neuron
- pi_bram_add  in  ADDR_W  read address from neuron
- po_valid  out  1  weight/input beat valid
- po_weight  out  DATA_W  weight beat
- po_input  out  DATA_W  input beat
- po_bias  out  DATA_W  bias register contents, held constant
- po_clc_accumulator  out  1  one-cycle accumulator-clear pulse
- po_accumulation_done  out  1  one-cycle end-of-accumulation pulse
- po_addr_err  out  1  sticky out-of-range read flag

## Operation
- States:
  - IDLE: pi_start=1 -> CLEAR.
  - CLEAR: one cycle, po_clc_accumulator=1 -> STREAM.
  - STREAM: serves requests; after the W_NUM-th accepted request -> DRAIN.
  - DRAIN: one cycle while the last beat is output -> DONE.
  - DONE: one cycle, po_accumulation_done=1, po_done=1 -> IDLE.
- Read requests are accepted only in STREAM. Requests in IDLE, CLEAR, DRAIN and DONE produce no beat and are not counted.
- A beat counter (ADDR_W+1 bits) increments on every accepted request, regardless of address; duplicate addresses each count. It is cleared in CLEAR.
- An accepted address >= W_NUM returns po_weight=po_input=0 with po_valid=1 and sets po_addr_err. That beat counts toward W_NUM.
- po_addr_err clears only when a new start is accepted or on reset.
- Host writes are accepted only in IDLE. A write in any other state, or with pi_wr_sel=11, or with address >= W_NUM, is dropped and pulses po_wr_err the next cycle.
- A bias write takes effect on po_bias the next cycle.
- pi_start while busy is ignored.
- Reset (async, any state):
  - FSM returns to IDLE.
  - Counter is cleared.
  - All outputs go to 0, including po_bias (the bias register is cleared).
  - Weight and input RAM contents are not cleared.
  - No done pulse is issued for an aborted evaluation.

## Timing
- pi_start sampled high at edge T: CLEAR during cycle T+1 (po_clc_accumulator=1, po_busy=1); STREAM from T+2.
- Request accepted at edge k: po_valid=1 with po_weight/po_input = RAM[pi_bram_add] during cycle k+1. Read latency is exactly 1. A request every cycle gives a gapless beat stream.
- po_valid is 0 in every cycle without a beat; po_weight and po_input are 0 when po_valid=0.
- W_NUM-th request accepted at edge k:
  - DRAIN during cycle k+1 carries the last beat.
  - DONE during cycle k+2.
  - IDLE and po_busy=0 at cycle k+3.
- A write in IDLE at edge t is readable by a request at edge t+1 or later.
- Minimum evaluation length is W_NUM+4 cycles from start to IDLE.

## Test plan
- Reset values: hold pi_rst=0 -> every output 0, state IDLE. Release reset, drive pi_bram_en=1 for 5 cycles -> po_valid stays 0.
- Full stream, W_NUM=784: load weight[i]=i and input[i]=16'hFFFF-i, set bias=16'h0A00, start, request addresses 0..783 back-to-back.
  - Beats carry (i, FFFF-i) one cycle after each request.
  - po_clc_accumulator is 1 exactly once, before the first beat.
  - po_accumulation_done and po_done are 1 exactly one cycle after beat 783.
  - po_bias=0A00 throughout.
- Gapped requests: request every third cycle -> 784 beats with matching gaps; done is still 1 cycle after the last beat.
- Out-of-range read: request address 800 mid-stream -> zero beat, po_addr_err=1 until the next start, done after 784 total beats.
- Write while busy and bad select: pi_wr_en during STREAM or with pi_wr_sel=11 -> po_wr_err pulses 1 cycle, RAM and bias unchanged (verify by a later read). A second pi_start during STREAM -> ignored.
- Reset mid-stream: assert pi_rst after 300 beats -> outputs 0 immediately with no done pulse. Then start a new evaluation -> RAM contents intact, full 784-beat evaluation completes.
